// File: rtl/ps2_cmd_sequencer_if.sv
// Byte-level link between the command sequencer and the PS/2 controller.
interface ps2_cmd_sequencer_if;
    logic [7:0] the_command;
    logic       send_command;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       cmd_sent;
    logic       cmd_timeout;

    // Sequencer side: issues commands, observes controller status and received bytes
    modport master (
        output the_command, send_command,
        input  rx_data, rx_en, cmd_sent, cmd_timeout
    );

    // Controller side
    modport slave (
        input  the_command, send_command,
        output rx_data, rx_en, cmd_sent, cmd_timeout
    );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer: arbitrates keyboard init and LED update,
// handles ACK/resend/timeout and strips consumed response bytes from the scan stream.
module ps2_cmd_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned BAT_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       init_req,
    input  logic                       led_req,
    input  logic [2:0]                 led_val,
    ps2_cmd_sequencer_if.master        ps2,
    output logic                       busy,
    output logic                       init_done,
    output logic                       led_done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [7:0]                 kb_data,
    output logic                       kb_valid
);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_LED      = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    localparam int unsigned T_MAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LAST   = TW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ACK_WAIT,
        S_RETRY,
        S_GAP,
        S_BAT_WAIT
    } state_t;

    state_t         state;
    logic           init_pend;
    logic           led_pend;
    logic [2:0]     led_latch;
    logic           op_led;
    logic           stage;
    logic [RW-1:0]  retry;
    logic [TW-1:0]  timer;
    logic [7:0]     cmd_q;
    logic           send_q;
    logic           consumed;

    assign ps2.the_command  = cmd_q;
    assign ps2.send_command = send_q;

    // Response bytes that belong to the command protocol and must not reach the decoders
    always_comb begin
        consumed = 1'b0;
        if (ps2.rx_en) begin
            if (state == S_ACK_WAIT)
                consumed = (ps2.rx_data == RSP_ACK) || (ps2.rx_data == RSP_RESEND);
            else if (state == S_BAT_WAIT)
                consumed = (ps2.rx_data == RSP_BAT_OK) || (ps2.rx_data == RSP_BAT_FAIL);
        end
    end

    // Sequencer FSM with registered outputs, request latching and scan-code forwarding
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            init_pend <= 1'b0;
            led_pend  <= 1'b0;
            led_latch <= 3'b000;
            op_led    <= 1'b0;
            stage     <= 1'b0;
            retry     <= '0;
            timer     <= '0;
            cmd_q     <= 8'h00;
            send_q    <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            led_done  <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            kb_data   <= 8'h00;
            kb_valid  <= 1'b0;
        end else begin
            init_done <= 1'b0;
            led_done  <= 1'b0;
            err       <= 1'b0;
            kb_valid  <= 1'b0;

            if (init_req)
                init_pend <= 1'b1;
            if (led_req) begin
                led_pend  <= 1'b1;
                led_latch <= led_val;
            end

            if (ps2.rx_en && !consumed) begin
                kb_data  <= ps2.rx_data;
                kb_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (init_pend) begin
                        op_led    <= 1'b0;
                        cmd_q     <= CMD_RESET;
                        init_pend <= init_req;
                        retry     <= '0;
                        send_q    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_SEND;
                    end else if (led_pend) begin
                        op_led    <= 1'b1;
                        stage     <= 1'b0;
                        cmd_q     <= CMD_LED;
                        led_pend  <= led_req;
                        retry     <= '0;
                        send_q    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (ps2.cmd_timeout) begin
                        send_q <= 1'b0;
                        state  <= S_RETRY;
                    end else if (ps2.cmd_sent) begin
                        send_q <= 1'b0;
                        timer  <= '0;
                        state  <= S_ACK_WAIT;
                    end
                end

                S_ACK_WAIT: begin
                    // Timer saturates so a byte arriving on the last cycle only delays the timeout
                    if (timer != ACK_LAST)
                        timer <= timer + TW'(1);
                    if (ps2.rx_en && ps2.rx_data == RSP_ACK) begin
                        if (!op_led) begin
                            timer <= '0;
                            state <= S_BAT_WAIT;
                        end else if (!stage) begin
                            stage <= 1'b1;
                            cmd_q <= {5'b00000, led_latch};
                            retry <= '0;
                            state <= S_GAP;
                        end else begin
                            led_done <= 1'b1;
                            busy     <= 1'b0;
                            retry    <= '0;
                            state    <= S_IDLE;
                        end
                    end else if (ps2.rx_en && ps2.rx_data == RSP_RESEND) begin
                        state <= S_RETRY;
                    end else if (!ps2.rx_en && timer == ACK_LAST) begin
                        state <= S_RETRY;
                    end
                end

                S_RETRY: begin
                    if (retry == RETRY_LAST) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                        busy     <= 1'b0;
                        retry    <= '0;
                        state    <= S_IDLE;
                    end else begin
                        retry <= retry + RW'(1);
                        state <= S_GAP;
                    end
                end

                S_GAP: begin
                    send_q <= 1'b1;
                    state  <= S_SEND;
                end

                S_BAT_WAIT: begin
                    if (timer != BAT_LAST)
                        timer <= timer + TW'(1);
                    if (ps2.rx_en && ps2.rx_data == RSP_BAT_OK) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        retry     <= '0;
                        state     <= S_IDLE;
                    end else if (ps2.rx_en && ps2.rx_data == RSP_BAT_FAIL) begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                        busy     <= 1'b0;
                        retry    <= '0;
                        state    <= S_IDLE;
                    end else if (timer == BAT_LAST) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        busy     <= 1'b0;
                        retry    <= '0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    send_q <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed self-checking bench for ps2_cmd_sequencer with short timeouts.
module tb_ps2_cmd_sequencer;

    logic       clock;
    logic       reset;
    logic       init_req;
    logic       led_req;
    logic [2:0] led_val;
    logic       busy;
    logic       init_done;
    logic       led_done;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] kb_data;
    logic       kb_valid;

    int vectors;
    int miscompares;
    int kb_cnt;
    int send_rises;
    int done_cnt;
    int led_done_cnt;
    int multi_cnt;
    logic send_prev;

    ps2_cmd_sequencer_if ps2_bus ();

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (100),
        .BAT_TIMEOUT (200),
        .MAX_RETRY   (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .init_req  (init_req),
        .led_req   (led_req),
        .led_val   (led_val),
        .ps2       (ps2_bus),
        .busy      (busy),
        .init_done (init_done),
        .led_done  (led_done),
        .err       (err),
        .err_code  (err_code),
        .kb_data   (kb_data),
        .kb_valid  (kb_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Event counters sampled mid-cycle
    initial begin
        kb_cnt = 0; send_rises = 0; done_cnt = 0; led_done_cnt = 0; multi_cnt = 0; send_prev = 1'b0;
    end
    always @(negedge clock) begin
        if (kb_valid === 1'b1) kb_cnt++;
        if (ps2_bus.send_command === 1'b1 && send_prev !== 1'b1) send_rises++;
        send_prev = ps2_bus.send_command;
        if (init_done === 1'b1) done_cnt++;
        if (led_done === 1'b1) led_done_cnt++;
        if (int'(init_done) + int'(led_done) + int'(err) > 1) multi_cnt++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_init();
        init_req = 1'b1; tick(); init_req = 1'b0;
    endtask

    task automatic pulse_sent();
        ps2_bus.cmd_sent = 1'b1; tick(); ps2_bus.cmd_sent = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        ps2_bus.rx_data = b; ps2_bus.rx_en = 1'b1; tick(); ps2_bus.rx_en = 1'b0;
    endtask

    task automatic wait_send(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (ps2_bus.send_command === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_err(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (err === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        vectors++; if (ps2_bus.send_command !== 1'b0) begin miscompares++; $display("FAIL reset_send: got %b want 0", ps2_bus.send_command); end
        vectors++; if (ps2_bus.the_command !== 8'h00) begin miscompares++; $display("FAIL reset_cmd: got %h want 00", ps2_bus.the_command); end
        vectors++; if ({busy, init_done, led_done, err, err_code, kb_valid} !== 7'b0) begin miscompares++; $display("FAIL reset_outs: got %b want 0000000", {busy, init_done, led_done, err, err_code, kb_valid}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_init();
        bit ok;
        int k0, d0;
        k0 = kb_cnt; d0 = done_cnt;
        pulse_init();
        wait_send(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL init_send_timeout: send_command never rose"); end
        vectors++; if (ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL init_cmd: got %h want FF", ps2_bus.the_command); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL init_busy: got %b want 1", busy); end
        repeat (10) tick();
        vectors++; if (ps2_bus.send_command !== 1'b1 || ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL init_hold: got %b/%h want 1/FF", ps2_bus.send_command, ps2_bus.the_command); end
        pulse_sent();
        vectors++; if (ps2_bus.send_command !== 1'b0) begin miscompares++; $display("FAIL init_drop: got %b want 0", ps2_bus.send_command); end
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        vectors++; if (init_done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL init_done: got done=%b busy=%b want 1/0", init_done, busy); end
        tick();
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL init_done_pulses: got %0d want 1", done_cnt - d0); end
        vectors++; if (kb_cnt - k0 !== 0) begin miscompares++; $display("FAIL init_kb_leak: got %0d strobes want 0", kb_cnt - k0); end
    endtask

    task automatic test_led();
        bit ok;
        int l0;
        l0 = led_done_cnt;
        led_val = 3'b101; led_req = 1'b1; tick(); led_req = 1'b0; led_val = 3'b000;
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hED) begin miscompares++; $display("FAIL led_cmd: got ok=%b %h want ED", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        vectors++; if (ps2_bus.send_command !== 1'b0) begin miscompares++; $display("FAIL led_gap: got %b want 0", ps2_bus.send_command); end
        tick();
        vectors++; if (ps2_bus.send_command !== 1'b1 || ps2_bus.the_command !== 8'h05) begin miscompares++; $display("FAIL led_data: got %b/%h want 1/05", ps2_bus.send_command, ps2_bus.the_command); end
        led_val = 3'b010; led_req = 1'b1; tick(); led_req = 1'b0; led_val = 3'b000;
        vectors++; if (ps2_bus.the_command !== 8'h05) begin miscompares++; $display("FAIL led_inflight: got %h want 05", ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        vectors++; if (led_done !== 1'b1) begin miscompares++; $display("FAIL led_done: got %b want 1", led_done); end
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hED) begin miscompares++; $display("FAIL led2_cmd: got ok=%b %h want ED", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'h02) begin miscompares++; $display("FAIL led2_data: got ok=%b %h want 02", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        tick();
        vectors++; if (led_done_cnt - l0 !== 2 || busy !== 1'b0) begin miscompares++; $display("FAIL led_done_count: got %0d busy=%b want 2/0", led_done_cnt - l0, busy); end
    endtask

    task automatic test_priority();
        bit ok;
        init_req = 1'b1; led_req = 1'b1; led_val = 3'b011; tick();
        init_req = 1'b0; led_req = 1'b0; led_val = 3'b000;
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL prio_first: got ok=%b %h want FF", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'h1D);
        vectors++; if (kb_valid !== 1'b1 || kb_data !== 8'h1D) begin miscompares++; $display("FAIL prio_fwd: got %b/%h want 1/1D", kb_valid, kb_data); end
        tick();
        vectors++; if (kb_valid !== 1'b0) begin miscompares++; $display("FAIL prio_strobe_len: got %b want 0", kb_valid); end
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL prio_init_done: got %b want 1", init_done); end
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hED) begin miscompares++; $display("FAIL prio_second: got ok=%b %h want ED", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'h03) begin miscompares++; $display("FAIL prio_data: got ok=%b %h want 03", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        vectors++; if (led_done !== 1'b1) begin miscompares++; $display("FAIL prio_led_done: got %b want 1", led_done); end
        tick();
    endtask

    task automatic test_resend();
        bit ok;
        int s0;
        s0 = send_rises;
        pulse_init();
        wait_send(20, ok);
        ps2_bus.cmd_timeout = 1'b1; ps2_bus.cmd_sent = 1'b1; tick();
        ps2_bus.cmd_timeout = 1'b0; ps2_bus.cmd_sent = 1'b0;
        vectors++; if (ps2_bus.send_command !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL resend_timeout_wins: got send=%b busy=%b want 0/1", ps2_bus.send_command, busy); end
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL resend_after_timeout: got ok=%b %h want FF", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFE);
        wait_send(20, ok);
        vectors++; if (!ok || ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL resend_after_fe: got ok=%b %h want FF", ok, ps2_bus.the_command); end
        pulse_sent();
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL resend_done: got %b want 1", init_done); end
        tick();
        vectors++; if (send_rises - s0 !== 3) begin miscompares++; $display("FAIL resend_passes: got %0d want 3", send_rises - s0); end
    endtask

    task automatic test_retry_exhaust();
        bit ok;
        int s0, n;
        s0 = send_rises;
        n = -1;
        pulse_init();
        for (int p = 0; p < 4; p++) begin
            wait_send(150, ok);
            vectors++; if (!ok || ps2_bus.the_command !== 8'hFF) begin miscompares++; $display("FAIL exhaust_pass%0d: got ok=%b %h want FF", p, ok, ps2_bus.the_command); end
            pulse_sent();
            if (p == 3) wait_err(150, n);
        end
        vectors++; if (n !== 101) begin miscompares++; $display("FAIL exhaust_latency: got %0d want 101", n); end
        vectors++; if (err_code !== 2'd1 || busy !== 1'b0) begin miscompares++; $display("FAIL exhaust_code: got code=%0d busy=%b want 1/0", err_code, busy); end
        tick();
        vectors++; if (send_rises - s0 !== 4 || err !== 1'b0) begin miscompares++; $display("FAIL exhaust_passes: got %0d err=%b want 4/0", send_rises - s0, err); end
    endtask

    task automatic test_bat();
        bit ok;
        int n;
        pulse_init();
        wait_send(20, ok);
        pulse_sent();
        rx_byte(8'hFA);
        rx_byte(8'hFA);
        vectors++; if (kb_valid !== 1'b1 || kb_data !== 8'hFA || busy !== 1'b1) begin miscompares++; $display("FAIL bat_fwd_fa: got %b/%h busy=%b want 1/FA/1", kb_valid, kb_data, busy); end
        rx_byte(8'hFC);
        vectors++; if (err !== 1'b1 || err_code !== 2'd2 || kb_valid !== 1'b0) begin miscompares++; $display("FAIL bat_fail: got err=%b code=%0d kbv=%b want 1/2/0", err, err_code, kb_valid); end
        tick();
        pulse_init();
        wait_send(20, ok);
        pulse_sent();
        rx_byte(8'hFA);
        wait_err(250, n);
        vectors++; if (n !== 200 || err_code !== 2'd3) begin miscompares++; $display("FAIL bat_timeout: got n=%0d code=%0d want 200/3", n, err_code); end
        tick();
        rx_byte(8'hAA);
        vectors++; if (kb_valid !== 1'b1 || kb_data !== 8'hAA) begin miscompares++; $display("FAIL idle_fwd_aa: got %b/%h want 1/AA", kb_valid, kb_data); end
        tick();
    endtask

    task automatic test_reset_in_send();
        bit ok;
        int s0;
        pulse_init();
        wait_send(20, ok);
        led_val = 3'b111; led_req = 1'b1; tick(); led_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        vectors++; if (ps2_bus.send_command !== 1'b0 || busy !== 1'b0 || ps2_bus.the_command !== 8'h00) begin miscompares++; $display("FAIL async_reset: got send=%b busy=%b cmd=%h want 0/0/00", ps2_bus.send_command, busy, ps2_bus.the_command); end
        vectors++; if (err_code !== 2'd0) begin miscompares++; $display("FAIL async_reset_code: got %0d want 0", err_code); end
        tick();
        reset = 1'b1;
        s0 = send_rises;
        repeat (5) tick();
        vectors++; if (busy !== 1'b0 || send_rises - s0 !== 0) begin miscompares++; $display("FAIL reset_pend_discard: got busy=%b sends=%0d want 0/0", busy, send_rises - s0); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; init_req = 1'b0; led_req = 1'b0; led_val = 3'b000;
        ps2_bus.rx_data = 8'h00; ps2_bus.rx_en = 1'b0;
        ps2_bus.cmd_sent = 1'b0; ps2_bus.cmd_timeout = 1'b0;

        test_reset();
        test_init();
        test_led();
        test_priority();
        test_resend();
        test_retry_exhaust();
        test_bat();
        test_reset_in_send();

        vectors++; if (multi_cnt !== 0) begin miscompares++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", multi_cnt); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
